// File: rtl/regbus_pkg.sv
// Shared types and constants for the register-bus transfer block.
// Swap states exist only when REGBUS_XFER_SWAP_EN is defined.
package regbus_pkg;

    function automatic int idx_w(input int nreg);
        return $clog2(nreg + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
`ifdef REGBUS_XFER_SWAP_EN
        SWAP0,
        SWAP1,
        SWAP2,
`endif
        DONE
    } state_e;

    localparam logic RST_READY = 1'b1;
    localparam logic RST_PULSE = 1'b0;

endpackage

// File: rtl/regbus_regfile.sv
// NREG x WIDTH register storage: one write port, flat read vector, async clear.
module regbus_regfile
    import regbus_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 4,
    localparam int IDXW  = idx_w(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [IDXW-1:0]         waddr_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [NREG*WIDTH-1:0]   regs_flat_o
);

    logic [NREG-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < NREG; i++) begin
                if (waddr_i == IDXW'(i)) mem_q[i] <= wdata_i;
            end
        end
    end

    assign regs_flat_o = mem_q;

endmodule

// File: rtl/regbus_xfer.sv
// Register-to-register bus transfer controller: move (and optional swap via
// macro REGBUS_XFER_SWAP_EN) between NREG registers or from in_data.
module regbus_xfer
    import regbus_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 4,
    localparam int IDXW  = idx_w(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [IDXW-1:0]         cmd_src,
    input  logic [IDXW-1:0]         cmd_dst,
    input  logic                    cmd_swap,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NREG*WIDTH-1:0]   regs_flat,
    output logic [WIDTH-1:0]        zbus,
    output logic                    done,
    output logic                    err
);

    state_e                     state_q;
    logic                       ready_q, done_q, err_q;
    logic [WIDTH-1:0]           zbus_q;
    logic [IDXW-1:0]            dst_q;
    logic [NREG-1:0][WIDTH-1:0] rd;
    logic [WIDTH-1:0]           src_val;
    logic                       illegal;
    logic                       we;
    logic [IDXW-1:0]            waddr;

`ifdef REGBUS_XFER_SWAP_EN
    logic [IDXW-1:0]            src_q;
    logic [WIDTH-1:0]           tmp_q;
    logic [WIDTH-1:0]           dst_val;
`else
    logic                       swap_unused;
    assign swap_unused = cmd_swap;
`endif

    assign rd = regs_flat;

    // Source value is captured onto the bus register at accept, so in_data
    // only needs to be valid on the accept edge.
    always_comb begin
        src_val = in_data;
        for (int i = 0; i < NREG; i++) begin
            if (cmd_src == IDXW'(i)) src_val = rd[i];
        end
    end

    always_comb begin
        illegal = (cmd_dst >= IDXW'(NREG)) || (cmd_src > IDXW'(NREG));
`ifdef REGBUS_XFER_SWAP_EN
        illegal = illegal || (cmd_swap && cmd_src == IDXW'(NREG));
`endif
    end

`ifdef REGBUS_XFER_SWAP_EN
    always_comb begin
        dst_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (dst_q == IDXW'(i)) dst_val = rd[i];
        end
    end
`endif

    always_comb begin
        we    = 1'b0;
        waddr = dst_q;
        case (state_q)
            MOVE:  we = 1'b1;
`ifdef REGBUS_XFER_SWAP_EN
            SWAP1: begin we = 1'b1; waddr = src_q; end
            SWAP2: we = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= RST_READY;
            done_q  <= RST_PULSE;
            err_q   <= RST_PULSE;
            zbus_q  <= '0;
            dst_q   <= '0;
`ifdef REGBUS_XFER_SWAP_EN
            src_q   <= '0;
            tmp_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    ready_q <= 1'b0;
                    dst_q   <= cmd_dst;
`ifdef REGBUS_XFER_SWAP_EN
                    src_q   <= cmd_src;
`endif
                    if (illegal) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
`ifdef REGBUS_XFER_SWAP_EN
                    end else if (cmd_swap) begin
                        state_q <= SWAP0;
                        zbus_q  <= src_val;
`endif
                    end else begin
                        state_q <= MOVE;
                        zbus_q  <= src_val;
                    end
                end
                MOVE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    zbus_q  <= '0;
                end
`ifdef REGBUS_XFER_SWAP_EN
                // src==dst falls out naturally: both writes restore the original.
                SWAP0: begin
                    tmp_q   <= zbus_q;
                    zbus_q  <= dst_val;
                    state_q <= SWAP1;
                end
                SWAP1: begin
                    zbus_q  <= tmp_q;
                    state_q <= SWAP2;
                end
                SWAP2: begin
                    zbus_q  <= '0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    zbus_q  <= '0;
                end
            endcase
        end
    end

    regbus_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (we),
        .waddr_i     (waddr),
        .wdata_i     (zbus_q),
        .regs_flat_o (regs_flat)
    );

    assign cmd_ready = ready_q;
    assign zbus      = zbus_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regbus_xfer.sv
// Bench for regbus_xfer (WIDTH=8, NREG=4): directed cases plus random commands
// against a register-array model; honours REGBUS_XFER_SWAP_EN.
module tb_regbus_xfer;

`ifdef REGBUS_XFER_SWAP_EN
    localparam bit SWAP_ON = 1'b1;
`else
    localparam bit SWAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_swap, done, err;
    logic [2:0]  cmd_src, cmd_dst;
    logic [7:0]  in_data, zbus;
    logic [31:0] regs_flat;

    logic [7:0]  m [4];
    int          n_chk = 0, n_err = 0, done_cnt = 0;
    int          nx_s, nx_d;
    bit          nx_sw;
    logic [7:0]  nx_din;

    regbus_xfer #(.WIDTH(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_swap(cmd_swap), .in_data(in_data),
        .regs_flat(regs_flat), .zbus(zbus), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = m[i];
        return v;
    endfunction

    // Called at a negedge; returns at a negedge one cycle after done.
    task automatic xfer(input int s, input int d, input bit sw, input logic [7:0] din, input bit nxt);
        bit         use_sw, ill;
        logic [7:0] sv, dv, t;
        int         lat, w;
        use_sw = sw && SWAP_ON;
        ill    = (d >= 4) || (s > 4) || (use_sw && s == 4);
        sv     = (s == 4) ? din : (s < 4 ? m[s] : 8'h00);
        dv     = (d < 4) ? m[d] : 8'h00;
        lat    = ill ? 1 : (use_sw ? 4 : 2);
        cmd_valid = 1'b1; cmd_src = 3'(s); cmd_dst = 3'(d); cmd_swap = sw; in_data = din;
        w = 0;
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        chk("accept_wait", 64'(w < 20), 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (nxt) begin
            cmd_src = 3'(nx_s); cmd_dst = 3'(nx_d); cmd_swap = nx_sw; in_data = nx_din;
        end else begin
            cmd_valid = 1'b0; in_data = ~din;
        end
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                chk("busy_done", 64'(done), 64'd0);
                chk("busy_ready", 64'(cmd_ready), 64'd0);
                if (k == 2 && use_sw) chk("zbus_swap1", 64'(zbus), 64'(dv));
                else                  chk("zbus_src", 64'(zbus), 64'(sv));
                @(negedge clk);
            end else begin
                chk("done", 64'(done), 64'd1);
                chk("err", 64'(err), 64'(ill));
                chk("zbus_done", 64'(zbus), 64'd0);
            end
        end
        @(negedge clk);
        chk("done_once", 64'(done), 64'd0);
        chk("ready_back", 64'(cmd_ready), 64'd1);
        if (!ill) begin
            if (use_sw) begin t = m[s]; m[s] = m[d]; m[d] = t; end
            else m[d] = sv;
        end
        chk("regs", 64'(regs_flat), 64'(model_flat()));
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_swap = 1'b0; in_data = '0;
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_regs", 64'(regs_flat), 64'd0);
        chk("rst_zbus", 64'(zbus), 64'd0);
        chk("rst_done", 64'({done, err}), 64'd0);

        xfer(4, 0, 0, 8'hAA, 0);             // load
        xfer(0, 2, 0, 8'h5C, 0);             // move reg0 -> reg2
        xfer(0, 4, 0, 8'h01, 0);             // illegal dst
        xfer(6, 1, 0, 8'h02, 0);             // illegal src
        xfer(4, 1, 0, 8'h11, 0);
        xfer(4, 3, 0, 8'h33, 0);
        xfer(1, 3, 1, 8'h00, 0);             // swap (or move when disabled)
        xfer(2, 2, 1, 8'h00, 0);             // same-register swap
        xfer(3, 3, 0, 8'h00, 0);             // same-register move
        xfer(4, 2, 1, 8'h9E, 0);             // swap from in_data: illegal only with swap

        // back-to-back with cmd_valid held high
        d0 = done_cnt;
        nx_s = 4; nx_d = 1; nx_sw = 1'b0; nx_din = 8'h5A;
        xfer(4, 0, 0, 8'hC3, 1);
        xfer(4, 1, 0, 8'h5A, 0);
        repeat (3) @(negedge clk);
        chk("b2b_dones", 64'(done_cnt - d0), 64'd2);

        for (int n = 0; n < 40; n++)
            xfer(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                 bit'($urandom_range(0, 1)), 8'($urandom), 0);

        // reset during MOVE
        xfer(4, 1, 0, 8'hE7, 0);
        cmd_valid = 1'b1; cmd_src = 3'd1; cmd_dst = 3'd2; cmd_swap = 1'b0; in_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_zbus", 64'(zbus), 64'hE7);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_regs", 64'(regs_flat), 64'd0);
        chk("mid_rst_out", 64'({zbus, done, err}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("mid_regs", 64'(regs_flat), 64'd0);
        chk("mid_nodone", 64'(done_cnt - d0), 64'd0);
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        xfer(4, 3, 0, 8'h42, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regbus_xfer.md
REGBUS_XFER -- requirements
Module: regbus_xfer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of every register and of the bus.
REQ-002 SHALL have parameter NREG, default 4: number of registers on the bus, legal range 2..16.
REQ-003 SHALL have localparam IDXW = $clog2(NREG+1): index width, where index NREG selects the external input source.
REQ-004 SHALL have port clk input 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid input 1: a transfer command is present.
REQ-007 SHALL have port cmd_ready output 1: the block accepts a command this cycle.
REQ-008 SHALL have port cmd_src input IDXW: source index; 0..NREG-1 selects a register, NREG selects in_data.
REQ-009 SHALL have port cmd_dst input IDXW: destination register index.
REQ-010 SHALL have port cmd_swap input 1: request an exchange instead of a move.
REQ-011 SHALL have port in_data input WIDTH: external bus source.
REQ-012 SHALL have port regs_flat output NREG*WIDTH: all registers, with register i at [i*WIDTH +: WIDTH].
REQ-013 SHALL have port zbus output WIDTH: value currently driven on the internal bus, muxed with no tristate.
REQ-014 SHALL have port done output 1: one-cycle pulse when a command completes.
REQ-015 SHALL have port err output 1: one-cycle pulse, coincident with done, when a command was illegal.

Function
REQ-016 SHALL implement FSM states IDLE, MOVE, SWAP0, SWAP1, SWAP2, DONE, with cmd_ready=1 only in IDLE.
REQ-017 SHALL accept a command on a rising edge where cmd_valid&&cmd_ready, latching src, dst, swap and in_data at that edge.
REQ-018 SHALL, on accept of a move, enter MOVE; in MOVE, zbus=source value, and dst is written at the edge ending MOVE; then DONE.
REQ-019 SHALL, on accept of a swap, run SWAP0 (zbus=reg[src], tmp<=zbus), then SWAP1 (zbus=reg[dst], reg[src]<=zbus), then SWAP2 (zbus=tmp, reg[dst]<=zbus), then DONE.
REQ-020 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-021 SHALL give a move latency of accept edge T, write at T+1, done high during cycle T+1..T+2, and next accept at T+3.
REQ-022 SHALL drive zbus=0 in IDLE and DONE.
REQ-023 SHALL treat cmd_dst>=NREG, cmd_src>NREG, or a swap with cmd_src=NREG as illegal: go to DONE directly, write nothing, and pulse err with done.
REQ-024 SHALL treat src==dst (legal) as a no-op: complete with done, err=0, register value unchanged, swap included.
REQ-025 SHALL ignore cmd_valid outside IDLE; commands are not queued.

Reset
REQ-026 SHALL, on rst_n low at any time (including mid-MOVE or mid-SWAP), set all registers, tmp, zbus, done and err to 0 and state to IDLE, with no partial write completing.
REQ-027 SHALL drive cmd_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL compile swap support (states SWAP0..SWAP2 and tmp register) only when macro REGBUS_XFER_SWAP_EN is defined.
REQ-029 SHALL, without REGBUS_XFER_SWAP_EN, keep the cmd_swap port, ignore it, and execute every command as a move.

Structure
REQ-030 SHALL place the FSM state enum, IDXW computation helper and reset constants in package regbus_pkg.
REQ-031 SHALL implement storage in sub-module regbus_regfile (NREG x WIDTH, one write port, flat read vector, async reset); the controller holds the FSM and bus mux.

Verification (WIDTH=8, NREG=4)
REQ-032 SHALL test load: src=4, dst=0, in_data=8'hAA -> reg0=8'hAA one edge after MOVE, done pulse, err=0.
REQ-033 SHALL test move: after REQ-032, src=0, dst=2 -> zbus=8'hAA during MOVE, reg2=8'hAA, reg0 unchanged.
REQ-034 SHALL test illegal: dst=4 -> no register changes, done=err=1 for one cycle, cmd_ready back to 1 next cycle.
REQ-035 SHALL test swap (macro on): reg1=8'h11, reg3=8'h33, swap 1<->3 -> reg1=8'h33, reg3=8'h11 after SWAP2, done pulse; with macro off, the same command yields reg3=8'h11 and reg1 unchanged.
REQ-036 SHALL test reset mid-op: assert rst_n low during MOVE -> all regs 0, no done, cmd_ready=1 after release.
REQ-037 SHALL test back-to-back: cmd_valid held high with two commands -> the second is accepted only after the first's done, with no drop and no duplicate.
